// File: rtl/car_park_occupancy.sv
// Car-park beam decoder: tracks entry/exit beam sequences and keeps a saturating occupancy count.
// Every output is registered. Event pulses are high on the same edge that the FSM returns to IDLE.
//
// state | meaning
// IDLE  | both beams clear, waiting
// EN_A  | entry started, outer beam blocked
// EN_AB | entry, both beams blocked
// EN_B  | entry, only inner beam still blocked
// EX_B  | exit started, inner beam blocked
// EX_AB | exit, both beams blocked
// EX_A  | exit, only outer beam still blocked
module car_park_occupancy #(
    parameter int MAX_COUNT = 15,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] count,
    output logic             enter_evt,
    output logic             exit_evt,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             seq_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_AB = 3'd5,
        EX_A  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

    state_t           r_state;
    state_t           w_next;
    logic             w_enter;
    logic             w_exit;
    logic             w_err;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_enter, r_exit, r_full, r_empty, r_ovf, r_unf, r_err;
    logic [1:0]       w_ab;

    assign w_ab = {a, b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_exit  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ab == 2'b10)      w_next = EN_A;
                else if (w_ab == 2'b01) w_next = EX_B;
            end
            EN_A: begin
                if (w_ab == 2'b11)      w_next = EN_AB;
                else if (w_ab == 2'b00) w_next = IDLE;
                else if (w_ab == 2'b01) begin w_next = IDLE; w_err = 1'b1; end
            end
            EN_AB: begin
                if (w_ab == 2'b01)      w_next = EN_B;
                else if (w_ab == 2'b10) w_next = EN_A;
                else if (w_ab == 2'b00) begin w_next = IDLE; w_err = 1'b1; end
            end
            EN_B: begin
                if (w_ab == 2'b00)      begin w_next = IDLE; w_enter = 1'b1; end
                else if (w_ab == 2'b11) w_next = EN_AB;
                else if (w_ab == 2'b10) begin w_next = IDLE; w_err = 1'b1; end
            end
            EX_B: begin
                if (w_ab == 2'b11)      w_next = EX_AB;
                else if (w_ab == 2'b00) w_next = IDLE;
                else if (w_ab == 2'b10) begin w_next = IDLE; w_err = 1'b1; end
            end
            EX_AB: begin
                if (w_ab == 2'b10)      w_next = EX_A;
                else if (w_ab == 2'b01) w_next = EX_B;
                else if (w_ab == 2'b00) begin w_next = IDLE; w_err = 1'b1; end
            end
            EX_A: begin
                if (w_ab == 2'b00)      begin w_next = IDLE; w_exit = 1'b1; end
                else if (w_ab == 2'b11) w_next = EX_AB;
                else if (w_ab == 2'b01) begin w_next = IDLE; w_err = 1'b1; end
            end
            default: w_next = IDLE;
        endcase
    end

    // Saturating count: holds at either end instead of wrapping.
    always_comb begin
        w_count_nxt = r_count;
        if (w_enter && (r_count != MAX_C))
            w_count_nxt = r_count + 1'b1;
        else if (w_exit && (r_count != '0))
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_enter <= w_enter;
            r_exit  <= w_exit;
            r_full  <= (w_count_nxt == MAX_C);
            r_empty <= (w_count_nxt == '0);
            r_ovf   <= w_enter && (r_count == MAX_C);
            r_unf   <= w_exit && (r_count == '0);
            r_err   <= w_err;
        end
    end

    assign count     = r_count;
    assign enter_evt = r_enter;
    assign exit_evt  = r_exit;
    assign full      = r_full;
    assign empty     = r_empty;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign seq_err   = r_err;

endmodule

// File: tb/tb_car_park_occupancy.sv
// Directed bench for car_park_occupancy; each driven step pushes its expected
// outputs to a scoreboard that is popped and compared after the sampling edge.
module tb_car_park_occupancy;

    logic       clk;
    logic       reset;
    logic       a;
    logic       b;
    logic [3:0] count;
    logic       enter_evt, exit_evt, full, empty, ovf, unf, seq_err;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    typedef struct {
        int   cnt;
        logic en;
        logic ex;
        logic ov;
        logic un;
        logic er;
    } exp_t;

    exp_t sb[$];

    car_park_occupancy #(.MAX_COUNT(15), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .count     (count),
        .enter_evt (enter_evt),
        .exit_evt  (exit_evt),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t quiet();
        exp_t e;
        e.cnt = exp_cnt; e.en = 0; e.ex = 0; e.ov = 0; e.un = 0; e.er = 0;
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        cmp({tag, ".count"},   {4'b0, count}, 8'(e.cnt));
        cmp({tag, ".enter"},   {7'b0, enter_evt}, {7'b0, e.en});
        cmp({tag, ".exit"},    {7'b0, exit_evt},  {7'b0, e.ex});
        cmp({tag, ".full"},    {7'b0, full},      {7'b0, (e.cnt == 15)});
        cmp({tag, ".empty"},   {7'b0, empty},     {7'b0, (e.cnt == 0)});
        cmp({tag, ".ovf"},     {7'b0, ovf},       {7'b0, e.ov});
        cmp({tag, ".unf"},     {7'b0, unf},       {7'b0, e.un});
        cmp({tag, ".seq_err"}, {7'b0, seq_err},   {7'b0, e.er});
    endtask

    task automatic step(input string tag, input logic ia, input logic ib, input exp_t e);
        exp_t got;
        @(negedge clk);
        a = ia;
        b = ib;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = sb.pop_front();
            check_all(tag, got);
        end
    endtask

    task automatic do_entry(input string tag);
        exp_t e;
        step({tag, ".a"},  1, 0, quiet());
        step({tag, ".ab"}, 1, 1, quiet());
        step({tag, ".b"},  0, 1, quiet());
        e = quiet();
        e.en = 1;
        if (exp_cnt < 15) exp_cnt++;
        else e.ov = 1;
        e.cnt = exp_cnt;
        step({tag, ".done"}, 0, 0, e);
    endtask

    task automatic do_exit(input string tag);
        exp_t e;
        step({tag, ".b"},  0, 1, quiet());
        step({tag, ".ab"}, 1, 1, quiet());
        step({tag, ".a"},  1, 0, quiet());
        e = quiet();
        e.ex = 1;
        if (exp_cnt > 0) exp_cnt--;
        else e.un = 1;
        e.cnt = exp_cnt;
        step({tag, ".done"}, 0, 0, e);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        a = 1'b0;
        b = 1'b0;
        exp_cnt = 0;
        #1;
        check_all({tag, ".async"}, quiet());
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all({tag, ".held"}, quiet());
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        exp_t e;
        reset = 1'b0;
        a = 1'b0;
        b = 1'b0;

        // Test 1: 5 entries then 3 exits
        apply_reset("t1.rst");
        for (int i = 0; i < 5; i++) do_entry($sformatf("t1.en%0d", i));
        for (int i = 0; i < 3; i++) do_exit($sformatf("t1.ex%0d", i));
        step("t1.idle", 0, 0, quiet());

        // Test 2: 17 entries, saturate at 15
        apply_reset("t2.rst");
        for (int i = 0; i < 17; i++) do_entry($sformatf("t2.en%0d", i));
        step("t2.idle", 0, 0, quiet());

        // Test 3: 4 entries then 8 exits, hold at 0
        apply_reset("t3.rst");
        for (int i = 0; i < 4; i++) do_entry($sformatf("t3.en%0d", i));
        for (int i = 0; i < 8; i++) do_exit($sformatf("t3.ex%0d", i));
        step("t3.idle", 0, 0, quiet());

        // Test 4: aborts and backing-out, count unchanged
        do_entry("t4.pre");
        step("t4.s0", 0, 0, quiet());
        step("t4.s1", 1, 0, quiet());
        step("t4.s2", 0, 0, quiet());
        step("t4.s3", 0, 0, quiet());
        step("t4.s4", 1, 0, quiet());
        step("t4.s5", 1, 1, quiet());
        step("t4.s6", 1, 0, quiet());
        step("t4.s7", 0, 0, quiet());
        step("t4.s8", 0, 0, quiet());

        // Test 5: illegal jump 10 -> 01
        step("t5.s0", 0, 0, quiet());
        step("t5.s1", 1, 0, quiet());
        e = quiet();
        e.er = 1;
        step("t5.err", 0, 1, e);
        step("t5.s3", 0, 0, quiet());
        do_entry("t5.post");

        // Test 6: reset while in EN_AB, then trailing 01,00
        step("t6.s0", 1, 0, quiet());
        step("t6.s1", 1, 1, quiet());
        apply_reset("t6.rst");
        step("t6.s2", 0, 1, quiet());
        step("t6.s3", 0, 0, quiet());
        step("t6.s4", 0, 0, quiet());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
